// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks registers FIRST_REG..LAST_REG through a register-file
// read port and streams each as a header byte plus four data bytes (MSB first).
//
// Ports:
//   CLK, RST      clock; asynchronous active-low reset
//   Start, Abort  dump request (idle only) / synchronous cancel
//   ReadReg       register-file read address (always idx)
//   ReadData      combinational register-file read data for ReadReg
//   OutByte       registered stream byte
//   OutValid      OutByte valid (registered, state SEND)
//   OutReady      downstream accepts OutByte this cycle
//   Busy          dump in progress (any state but IDLE)
//   Done          one-cycle pulse after the last byte of a completed dump

module reg_dump_reader #(
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic        Abort,
    output logic [4:0]  ReadReg,
    input  logic [31:0] ReadData,
    output logic [7:0]  OutByte,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Busy,
    output logic        Done
);

    localparam logic [4:0] FIRST_IDX = FIRST_REG[4:0];
    localparam logic [4:0] LAST_IDX  = LAST_REG[4:0];

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [4:0]  idx;
    logic [4:0]  idxNext;
    logic [31:0] shadow;
    logic [31:0] shadowNext;
    logic [2:0]  byteCnt;
    logic [2:0]  byteCntNext;
    logic [7:0]  outByteQ;
    logic [7:0]  outByteNext;
    logic [7:0]  followByte;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            idx      <= FIRST_IDX;
            shadow   <= '0;
            byteCnt  <= '0;
            outByteQ <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            shadow   <= shadowNext;
            byteCnt  <= byteCntNext;
            outByteQ <= outByteNext;
        end
    end

    // Byte that follows the one currently offered, so OutByte can stay
    // registered: it is loaded on the same edge that accepts the current byte.
    always_comb begin
        followByte = outByteQ;
        case (byteCnt)
            3'd0:    followByte = shadow[31:24];
            3'd1:    followByte = shadow[23:16];
            3'd2:    followByte = shadow[15:8];
            3'd3:    followByte = shadow[7:0];
            default: followByte = outByteQ;
        endcase
    end

    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        shadowNext  = shadow;
        byteCntNext = byteCnt;
        outByteNext = outByteQ;

        unique case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    idxNext   = FIRST_IDX;
                    stateNext = CAPTURE;
                end
            end

            CAPTURE: begin
                if (Abort) begin
                    stateNext = IDLE;
                end else begin
                    // Snapshot now; later writes to this register are not seen.
                    shadowNext  = ReadData;
                    byteCntNext = '0;
                    outByteNext = {3'b000, idx};
                    stateNext   = SEND;
                end
            end

            SEND: begin
                // Abort wins over a transfer in the same cycle.
                if (Abort) begin
                    stateNext = IDLE;
                end else if (OutReady) begin
                    byteCntNext = byteCnt + 3'd1;
                    if (byteCnt == 3'd4) begin
                        if (idx == LAST_IDX) begin
                            stateNext = DONE;
                        end else begin
                            idxNext   = idx + 5'd1;
                            stateNext = CAPTURE;
                        end
                    end else begin
                        outByteNext = followByte;
                    end
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign ReadReg  = idx;
    assign OutByte  = outByteQ;
    assign OutValid = (state == SEND);
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed/randomized bench for reg_dump_reader with a
// queue-based reference stream built from the register contents.

module tb_reg_dump_reader;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    logic [31:0] regs [32];

    logic        start  [3];
    logic        abort  [3];
    logic        ready  [3];
    logic [4:0]  rdReg  [3];
    logic [31:0] rdData [3];
    logic [7:0]  oByte  [3];
    logic        oValid [3];
    logic        busy   [3];
    logic        done   [3];

    assign rdData[0] = regs[rdReg[0]];
    assign rdData[1] = regs[rdReg[1]];
    assign rdData[2] = regs[rdReg[2]];

    reg_dump_reader u0 (
        .CLK(CLK), .RST(RST), .Start(start[0]), .Abort(abort[0]),
        .ReadReg(rdReg[0]), .ReadData(rdData[0]), .OutByte(oByte[0]),
        .OutValid(oValid[0]), .OutReady(ready[0]), .Busy(busy[0]),
        .Done(done[0])
    );

    reg_dump_reader #(.FIRST_REG(1), .LAST_REG(2)) u1 (
        .CLK(CLK), .RST(RST), .Start(start[1]), .Abort(abort[1]),
        .ReadReg(rdReg[1]), .ReadData(rdData[1]), .OutByte(oByte[1]),
        .OutValid(oValid[1]), .OutReady(ready[1]), .Busy(busy[1]),
        .Done(done[1])
    );

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(0)) u2 (
        .CLK(CLK), .RST(RST), .Start(start[2]), .Abort(abort[2]),
        .ReadReg(rdReg[2]), .ReadData(rdData[2]), .OutByte(oByte[2]),
        .OutValid(oValid[2]), .OutReady(ready[2]), .Busy(busy[2]),
        .Done(done[2])
    );

    int nComp = 0;
    int nBad  = 0;

    logic [7:0] got  [$];
    logic [7:0] expq [$];
    int doneCnt, busyCyc, doneAt, endCyc, abortCyc, stallErr;

    function automatic int firstOf(input int u);
        return (u == 0) ? 1 : (u == 1) ? 1 : 0;
    endfunction

    function automatic int lastOf(input int u);
        return (u == 0) ? 31 : (u == 1) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nComp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference stream: per register a header byte then the value MSB first.
    task automatic buildExp(input int u);
        expq.delete();
        for (int r = firstOf(u); r <= lastOf(u); r++) begin
            expq.push_back(8'(r));
            for (int b = 3; b >= 0; b--)
                expq.push_back(8'(regs[r] >> (8 * b)));
        end
    endtask

    task automatic compareStream(input string tag, input int n);
        int lim;
        if (n < 0) begin
            check({tag, ".len"}, 32'(got.size()), 32'(expq.size()));
            lim = expq.size();
        end else begin
            lim = n;
        end
        for (int i = 0; i < lim; i++)
            if (i < got.size() && i < expq.size())
                check($sformatf("%s.b%0d", tag, i), 32'(got[i]), 32'(expq[i]));
    endtask

    // Drives one dump on instance u; called and returns at a negedge.
    task automatic runDump(input int u, input int pct, input int budget,
                           input int wrCyc, input int wrReg,
                           input logic [31:0] wrVal, input int stCyc,
                           input int abortIdx);
        bit stall;
        bit timedOut;
        logic [7:0] held;
        got.delete();
        doneCnt  = 0;
        busyCyc  = 0;
        doneAt   = -1;
        endCyc   = -1;
        abortCyc = -1;
        stallErr = 0;
        timedOut = 1'b1;
        stall    = 1'b0;
        held     = '0;
        start[u] = 1'b1;
        @(negedge CLK);
        start[u] = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            abort[u] = 1'b0;
            if (stall && (oValid[u] !== 1'b1 || oByte[u] !== held))
                stallErr++;
            if (busy[u] === 1'b1)
                busyCyc++;
            if (done[u] === 1'b1) begin
                doneCnt++;
                if (doneAt < 0)
                    doneAt = cyc;
            end
            if (busy[u] !== 1'b1) begin
                endCyc   = cyc;
                timedOut = 1'b0;
                break;
            end
            if (cyc == wrCyc)
                regs[wrReg] = wrVal;
            start[u] = (cyc == stCyc);
            ready[u] = ($urandom_range(99) < pct);
            if (oValid[u] && got.size() == abortIdx && abortCyc < 0) begin
                abort[u] = 1'b1;
                abortCyc = cyc;
            end else if (oValid[u] && ready[u]) begin
                got.push_back(oByte[u]);
            end
            stall = oValid[u] && !ready[u] && !abort[u];
            held  = oByte[u];
            @(negedge CLK);
        end
        start[u] = 1'b0;
        abort[u] = 1'b0;
        ready[u] = 1'b0;
        check($sformatf("u%0d.timeout", u), 32'(timedOut), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = '0;
        for (int u = 0; u < 3; u++) begin
            start[u] = 1'b0;
            abort[u] = 1'b0;
            ready[u] = 1'b0;
        end

        // Reset state
        #12;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst.u%0d.ReadReg", u), 32'(rdReg[u]),
                  32'(firstOf(u)));
            check($sformatf("rst.u%0d.outs", u),
                  32'({oByte[u], oValid[u], busy[u], done[u]}), 32'd0);
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Two-register dump, back-to-back bytes and exact timing
        regs[1] = 32'h12345678;
        regs[2] = 32'hDEADBEEF;
        buildExp(1);
        runDump(1, 100, 100, -1, 0, 32'h0, -1, -1);
        compareStream("two", -1);
        check("two.doneCnt", 32'(doneCnt), 32'd1);
        check("two.doneAt", 32'(doneAt), 32'd12);
        check("two.busyCyc", 32'(busyCyc), 32'd13);

        // Single register, r0 read as returned
        regs[0] = 32'hC0FFEE01;
        buildExp(2);
        runDump(2, 50, 300, -1, 0, 32'h0, -1, -1);
        compareStream("one", -1);
        check("one.doneCnt", 32'(doneCnt), 32'd1);
        check("one.stall", 32'(stallErr), 32'd0);

        // Default range with 30% ready duty
        for (int i = 0; i < 32; i++)
            regs[i] = 32'(i) * 32'h01010101;
        buildExp(0);
        runDump(0, 30, 5000, -1, 0, 32'h0, -1, -1);
        compareStream("rand", -1);
        check("rand.doneCnt", 32'(doneCnt), 32'd1);
        check("rand.stall", 32'(stallErr), 32'd0);
        check("rand.busyLow", 32'(busy[0]), 32'd0);

        // Full-speed default dump; Start pulsed during DONE is dropped
        buildExp(0);
        runDump(0, 100, 400, -1, 0, 32'h0, 186, -1);
        compareStream("full", -1);
        check("full.busyCyc", 32'(busyCyc), 32'd187);
        check("full.doneAt", 32'(doneAt), 32'd186);
        repeat (3) @(negedge CLK);
        check("full.noQueue", 32'(busy[0]), 32'd0);

        // r1 written during its SEND phase; Start while busy in r2
        buildExp(0);
        runDump(0, 100, 400, 3, 1, 32'hAAAAAAAA, 10, -1);
        compareStream("snap", -1);
        check("snap.doneCnt", 32'(doneCnt), 32'd1);
        repeat (3) @(negedge CLK);
        check("snap.noQueue", 32'(busy[0]), 32'd0);
        buildExp(0);
        runDump(0, 40, 5000, -1, 0, 32'h0, -1, -1);
        compareStream("snap2", -1);
        check("snap2.r1", 32'(got.size() > 1 ? got[1] : 8'h00), 32'hAA);

        // Abort while byte 3 of r5 is offered
        buildExp(0);
        runDump(0, 60, 5000, -1, 0, 32'h0, -1, 23);
        check("abort.len", 32'(got.size()), 32'd23);
        compareStream("abort", 23);
        check("abort.doneCnt", 32'(doneCnt), 32'd0);
        check("abort.drop", 32'(endCyc - abortCyc), 32'd1);
        check("abort.valid", 32'(oValid[0]), 32'd0);
        runDump(0, 70, 5000, -1, 0, 32'h0, -1, -1);
        compareStream("restart", -1);
        check("restart.doneCnt", 32'(doneCnt), 32'd1);

        // Start together with Abort in IDLE
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("sa.busy", 32'(busy[0]), 32'd0);
        @(negedge CLK);
        check("sa.busy2", 32'({busy[0], oValid[0]}), 32'd0);

        // Asynchronous reset in the middle of r2's SEND phase
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        repeat (8) @(negedge CLK);
        check("mid.valid", 32'(oValid[0]), 32'd1);
        check("mid.ReadReg", 32'(rdReg[0]), 32'd2);
        ready[0] = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        check("arst.ReadReg", 32'(rdReg[0]), 32'd1);
        check("arst.OutByte", 32'(oByte[0]), 32'd0);
        check("arst.flags", 32'({oValid[0], busy[0], done[0]}), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        buildExp(0);
        runDump(0, 50, 5000, -1, 0, 32'h0, -1, -1);
        compareStream("postrst", -1);
        check("postrst.doneCnt", 32'(doneCnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nBad);
        $finish;
    end

endmodule
